// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for a single-port word-addressed data memory
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              addr_err
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(LOCK_MAX);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    typedef enum logic {ARB, LOCK} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [LOCK_W-1:0] lock_cnt, lock_nxt;
    logic              hold_wait, hold_nxt;
    logic              gnt_cpu, gnt_dma, owned, in_range, own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            wait_cnt  <= '0;
            lock_cnt  <= '0;
            hold_wait <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            lock_cnt  <= lock_nxt;
            hold_wait <= hold_nxt;
        end
    end

    always_comb begin
        gnt_cpu   = 1'b0;
        gnt_dma   = 1'b0;
        state_nxt = state;
        lock_nxt  = lock_cnt;
        hold_nxt  = 1'b0;
        case (state)
            ARB: begin
                if (dma_req && (!cpu_req || wait_cnt == WAIT_LIM)) begin
                    gnt_dma = 1'b1;
                    if (dma_lock) begin
                        if (LOCK_MAX > 1) begin
                            state_nxt = LOCK;
                            lock_nxt  = LOCK_W'(1);
                        end else begin
                            hold_nxt = 1'b1;
                        end
                    end
                end else if (cpu_req) begin
                    gnt_cpu = 1'b1;
                end
            end
            LOCK: begin
                if (dma_req) begin
                    gnt_dma = 1'b1;
                    // lock_cnt counts burst grants already made; this one is the (lock_cnt+1)th
                    if (lock_cnt + LOCK_W'(1) == LOCK_LIM) begin
                        state_nxt = ARB;
                        lock_nxt  = '0;
                        hold_nxt  = 1'b1;
                    end else if (!dma_lock) begin
                        state_nxt = ARB;
                        lock_nxt  = '0;
                    end else begin
                        lock_nxt = lock_cnt + LOCK_W'(1);
                    end
                end else begin
                    state_nxt = ARB;
                    lock_nxt  = '0;
                    gnt_cpu   = cpu_req;
                end
            end
            default: state_nxt = ARB;
        endcase
        if (!rst_n) begin
            gnt_cpu = 1'b0;
            gnt_dma = 1'b0;
        end

        // Holding at zero right after a forced release lets the CPU win the next contention
        if (!dma_req || gnt_dma || hold_wait) begin
            wait_nxt = '0;
        end else if (wait_cnt != WAIT_LIM) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end else begin
            wait_nxt = wait_cnt;
        end
    end

    always_comb begin
        owned     = gnt_cpu | gnt_dma;
        own_addr  = gnt_dma ? dma_addr  : (gnt_cpu ? cpu_addr  : '0);
        own_wdata = gnt_dma ? dma_wdata : (gnt_cpu ? cpu_wdata : '0);
        own_we    = gnt_dma ? dma_we    : (gnt_cpu & cpu_we);
        in_range  = own_addr < DEPTH_A;

        mem_addr  = own_addr;
        mem_wdata = own_wdata;
        mem_we    = own_we & in_range;
        addr_err  = owned & ~in_range;
        cpu_rdata = (gnt_cpu && in_range) ? mem_rdata : '0;
        dma_rdata = (gnt_dma && in_range) ? mem_rdata : '0;
        cpu_stall = rst_n & cpu_req & ~gnt_cpu;
        dma_gnt   = gnt_dma;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int DEPTH    = 1024;
    localparam int MAX_WAIT = 4;
    localparam int LOCK_MAX = 8;
    localparam int IW       = $clog2(DEPTH);
    localparam int VW       = 4 + ADDR_W + 3 * DATA_W;
    localparam logic [ADDR_W-1:0] DEPTH_A = DEPTH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req, cpu_we, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dma_req, dma_we, dma_lock, dma_gnt;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we, addr_err;

    logic [DATA_W-1:0] tb_mem  [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    bit m_locked, m_hold;
    int m_wait, m_burst;
    logic              e_dma_gnt, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [VW-1:0]     e_vec, obs;

    dmem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < DEPTH_A) ? tb_mem[mem_addr[IW-1:0]] : '0;
    always @(posedge clk) if (mem_we && mem_addr < DEPTH_A) tb_mem[mem_addr[IW-1:0]] <= mem_wdata;

    assign obs = {cpu_stall, dma_gnt, mem_we, addr_err, mem_addr, mem_wdata, cpu_rdata, dma_rdata};

    task automatic drive(input bit cr, input bit cw, input logic [ADDR_W-1:0] ca,
                         input logic [DATA_W-1:0] cd, input bit dr, input bit dw, input bit dl,
                         input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic model_reset();
        m_locked = 0; m_hold = 0; m_wait = 0; m_burst = 0;
    endtask

    // Expected outputs for the current inputs and model state
    task automatic model_eval();
        bit cg, dg, we, inr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd, rd;
        cg = 0; dg = 0;
        if (m_locked && dma_req) dg = 1;
        else if (!m_locked && dma_req && (!cpu_req || m_wait == MAX_WAIT)) dg = 1;
        else if (cpu_req) cg = 1;
        a   = dg ? dma_addr : (cg ? cpu_addr : '0);
        wd  = dg ? dma_wdata : (cg ? cpu_wdata : '0);
        we  = dg ? dma_we : (cg && cpu_we);
        inr = a < DEPTH_A;
        rd  = inr ? ref_mem[a[IW-1:0]] : '0;
        e_dma_gnt = dg; e_we = we && inr; e_addr = a; e_wdata = wd;
        e_vec = {cpu_req && !cg, dg, we && inr, (cg || dg) && !inr, a, wd,
                 (cg && inr) ? rd : '0, (dg && inr) ? rd : '0};
    endtask

    task automatic model_step();
        bit hold_now;
        if (e_we) ref_mem[e_addr[IW-1:0]] = e_wdata;
        hold_now = m_hold;
        m_hold = 0;
        if (m_locked) begin
            if (!dma_req) m_locked = 0;
            else begin
                m_burst++;
                if (m_burst >= LOCK_MAX) begin m_locked = 0; m_hold = 1; end
                else if (!dma_lock) m_locked = 0;
            end
        end else if (e_dma_gnt && dma_lock) begin
            m_burst = 1;
            if (LOCK_MAX == 1) m_hold = 1; else m_locked = 1;
        end
        if (!dma_req || e_dma_gnt || hold_now) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        model_eval();
        advance();
    endtask

    task automatic test_reset();
        drive(1, 1, 32'd3, 32'h1111_2222, 1, 1, 1, 32'd4, 32'h3333_4444);
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        idle_cycle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
            model_eval();
            @(negedge clk);
            checks++;
            if (obs !== e_vec) begin errors++; $display("FAIL idle cyc %0d got %h exp %h", i, obs, e_vec); end
            checks++;
            if ({mem_we, mem_addr, cpu_stall, dma_gnt} !== '0) begin
                errors++; $display("FAIL idle_quiet cyc %0d got %b/%h/%b/%b exp 0", i, mem_we, mem_addr, cpu_stall, dma_gnt);
            end
            advance();
        end
        drive(1, 0, 32'd1, '0, 1, 0, 0, 32'd2, '0);
        model_eval();
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++; $display("FAIL idle_then_contend got gnt=%b stall=%b exp gnt=0 stall=0", dma_gnt, cpu_stall);
        end
        advance();
        idle_cycle();
    endtask

    task automatic test_cpu_rw();
        drive(1, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, 0, '0, '0);
        model_eval();
        @(negedge clk);
        checks++;
        if (obs !== e_vec) begin errors++; $display("FAIL cpu_write got %h exp %h", obs, e_vec); end
        checks++;
        if (mem_we !== 1'b1 || cpu_stall !== 1'b0) begin
            errors++; $display("FAIL cpu_write_we got we=%b stall=%b exp we=1 stall=0", mem_we, cpu_stall);
        end
        advance();
        drive(1, 0, 32'd5, '0, 0, 0, 0, '0, '0);
        model_eval();
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 32'hDEAD_BEEF || cpu_stall !== 1'b0) begin
            errors++; $display("FAIL cpu_read got %h stall=%b exp deadbeef stall=0", cpu_rdata, cpu_stall);
        end
        advance();
        idle_cycle();
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 32'(i), '0, 1, 1, 0, 32'(100 + i), 32'(i * 7 + 1));
            model_eval();
            @(negedge clk);
            checks++;
            if (obs !== e_vec) begin errors++; $display("FAIL starve cyc %0d got %h exp %h", i, obs, e_vec); end
            checks++;
            if (dma_gnt !== (i % 5 == 4) || cpu_stall !== (i % 5 == 4)) begin
                errors++; $display("FAIL starve_pattern cyc %0d got gnt=%b stall=%b exp %b", i, dma_gnt, cpu_stall, (i % 5 == 4));
            end
            advance();
        end
        idle_cycle();
    endtask

    task automatic test_lock_burst();
        for (int i = 0; i < 15; i++) begin
            drive(i > 0, 0, 32'd9, '0, i < 12, 1, i < 12, 32'(200 + i), 32'(i + 50));
            model_eval();
            @(negedge clk);
            checks++;
            if (obs !== e_vec) begin errors++; $display("FAIL lock cyc %0d got %h exp %h", i, obs, e_vec); end
            if (i <= 8) begin
                checks++;
                if (dma_gnt !== (i < 8) || cpu_stall !== (i > 0 && i < 8)) begin
                    errors++; $display("FAIL lock_limit cyc %0d got gnt=%b stall=%b exp gnt=%b stall=%b",
                                       i, dma_gnt, cpu_stall, (i < 8), (i > 0 && i < 8));
                end
            end
            advance();
        end
        idle_cycle();
    endtask

    task automatic test_range();
        drive(1, 1, 32'd0, 32'h1234_5678, 0, 0, 0, '0, '0);
        model_eval();
        advance();
        drive(1, 1, DEPTH_A, 32'hCAFE_F00D, 0, 0, 0, '0, '0);
        model_eval();
        @(negedge clk);
        checks++;
        if (obs !== e_vec) begin errors++; $display("FAIL range_write got %h exp %h", obs, e_vec); end
        checks++;
        if (addr_err !== 1'b1 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++; $display("FAIL range_err got err=%b we=%b stall=%b exp 1/0/0", addr_err, mem_we, cpu_stall);
        end
        advance();
        drive(1, 0, 32'd0, '0, 0, 0, 0, '0, '0);
        model_eval();
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL range_keep got %h exp 12345678", cpu_rdata); end
        advance();
        drive(0, 0, '0, '0, 1, 0, 0, DEPTH_A + 3, '0);
        model_eval();
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1 || addr_err !== 1'b1 || dma_rdata !== '0) begin
            errors++; $display("FAIL range_dma got gnt=%b err=%b rd=%h exp 1/1/0", dma_gnt, addr_err, dma_rdata);
        end
        advance();
        idle_cycle();
    endtask

    task automatic test_reset_mid_lock();
        for (int i = 0; i < 2; i++) begin
            drive(i > 0, 0, 32'd1, '0, 1, 1, 1, 32'(300 + i), 32'(i));
            model_eval();
            @(negedge clk);
            checks++;
            if (obs !== e_vec) begin errors++; $display("FAIL midlock cyc %0d got %h exp %h", i, obs, e_vec); end
            advance();
        end
        drive(1, 0, 32'd1, '0, 1, 1, 1, 32'd302, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL midlock_reset got %h exp 0", obs); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 0, 32'd7, '0, 0, 0, 0, '0, '0);
        model_eval();
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || obs !== e_vec) begin
            errors++; $display("FAIL after_reset_cpu got %h exp %h", obs, e_vec);
        end
        advance();
        drive(1, 0, 32'd7, '0, 1, 1, 1, 32'd8, '0);
        model_eval();
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b0 || obs !== e_vec) begin
            errors++; $display("FAIL after_reset_rereq got %h exp %h", obs, e_vec);
        end
        advance();
        idle_cycle();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] ca, da;
        for (int i = 0; i < 400; i++) begin
            ca = ($urandom_range(0, 9) == 0) ? DEPTH_A + $urandom_range(0, 3) : 32'($urandom_range(0, 15));
            da = ($urandom_range(0, 9) == 0) ? DEPTH_A - 1 + $urandom_range(0, 2) : 32'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ca, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0, da, $urandom);
            model_eval();
            @(negedge clk);
            checks++;
            if (obs !== e_vec) begin errors++; $display("FAIL random cyc %0d got %h exp %h", i, obs, e_vec); end
            advance();
        end
        idle_cycle();
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            tb_mem[i]  = v;
            ref_mem[i] = v;
        end
        model_reset();
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_idle();
        test_cpu_rw();
        test_starvation();
        test_lock_burst();
        test_range();
        test_reset_mid_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
